// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL widths and the integrity-protected data word type.
package tlul_pkg;
  localparam int DataMaxWidth = 32;
  localparam int DataIntgWidth = 7;
  typedef logic [DataMaxWidth+DataIntgWidth-1:0] tl_data_intg_t;
endpackage

// File: rtl/tlul_data_integ_enc.sv
// tlul_data_integ_enc: inverted Hsiao SECDED 39/32 encoder, {check, data}.
module tlul_data_integ_enc
  import tlul_pkg::*;
(
  input  logic [DataMaxWidth-1:0] data_i,
  output tl_data_intg_t           data_intg_o
);
  localparam logic [DataIntgWidth-1:0] Inv = 7'h2A;
  localparam logic [DataMaxWidth-1:0] Mask [DataIntgWidth] = '{
    32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
    32'hC2C1323B, 32'h2DCC624C, 32'h98505586
  };
  logic [DataIntgWidth-1:0] chk;
  for (genvar i = 0; i < DataIntgWidth; i++) begin : g_chk
    assign chk[i] = ^(data_i & Mask[i]) ^ Inv[i];
  end
  assign data_intg_o = {chk, data_i};
endmodule

// File: rtl/tlul_rr_arb.sv
// tlul_rr_arb: combinational round-robin arbiter; search starts at ptr and wraps modulo N.
module tlul_rr_arb #(
  parameter  int N    = 4,
  localparam int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);
  int j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    // Walk from the farthest offset back to ptr so the nearest valid requester wins.
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (en && req[j]) begin
        gnt = N'(1) << j;
        idx = IdxW'(j);
      end
    end
  end
endmodule

// File: rtl/tlul_data_intg_arb.sv
// tlul_data_intg_arb: shares one integrity encoder between NumReq requesters via round-robin,
// with a single registered output stage tagged by requester index.
module tlul_data_intg_arb
  import tlul_pkg::*;
#(
  parameter  int NumReq = 4,
  localparam int IdxW   = $clog2(NumReq)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  input  logic [NumReq*DataMaxWidth-1:0] req_data_i,
  output logic [NumReq-1:0]              req_ready_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output tl_data_intg_t                  out_data_intg_o,
  output logic [IdxW-1:0]                out_idx_o,
  output logic                           busy_o
);
  logic [IdxW-1:0] ptr, gnt_idx;
  logic            load_en;
  tl_data_intg_t   enc;
  // Reset gates the enable so no requester sees an accept while the stage is being cleared.
  assign load_en = (~out_valid_o | out_ready_i) & ~rst_i;
  assign busy_o  = out_valid_o | (|req_valid_i);
  tlul_rr_arb #(.N(NumReq)) u_arb (
    .req (req_valid_i),
    .ptr (ptr),
    .en  (load_en),
    .gnt (req_ready_o),
    .idx (gnt_idx)
  );
  tlul_data_integ_enc u_enc (
    .data_i      (req_data_i[int'(gnt_idx)*DataMaxWidth +: DataMaxWidth]),
    .data_intg_o (enc)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o     <= 1'b0;
      out_data_intg_o <= '0;
      out_idx_o       <= '0;
      ptr             <= '0;
    end else if (|req_ready_o) begin
      out_valid_o     <= 1'b1;
      out_data_intg_o <= enc;
      out_idx_o       <= gnt_idx;
      ptr             <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end
endmodule
